// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, position strobes,
// and a pin-side delay line that keeps sync/blank aligned with the registered RGB path.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 2) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be >= 2");
    end
    if (SYNC_DELAY < 1) begin : g_chk_dly
        $error("vga_timing_gen: SYNC_DELAY must be >= 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end

    // ------------------------------------------------------------------
    // Pixel-rate divider and DAC clock
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_div_last;
    logic             r_vga_clk;

    assign w_div_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_div_nxt  = w_div_last ? '0 : r_div_cnt + DIV_W'(1);

    // VGA_CLK follows the next divider phase so its rising edge sits mid-pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_vga_clk <= (w_div_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_div_last) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Position decodes (undelayed, consumed by the fetch stage)
    // ------------------------------------------------------------------
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_video_on;
    logic        w_hs;
    logic        w_vs;

    // 11-bit compares keep sync windows ending at 1024 representable.
    assign w_h_ext    = {1'b0, r_h_cnt};
    assign w_v_ext    = {1'b0, r_v_cnt};
    assign w_video_on = (w_h_ext < 11'(H_VISIBLE)) && (w_v_ext < 11'(V_VISIBLE));
    assign w_hs       = !((w_h_ext >= 11'(HS_START)) && (w_h_ext < 11'(HS_END)));
    assign w_vs       = !((w_v_ext >= 11'(VS_START)) && (w_v_ext < 11'(VS_END)));

    // ------------------------------------------------------------------
    // Pin-side delay line, clocked every clk to track the RGB register
    // ------------------------------------------------------------------
    logic [SYNC_DELAY-1:0] r_hs_dly;
    logic [SYNC_DELAY-1:0] r_vs_dly;
    logic [SYNC_DELAY-1:0] r_blank_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_dly    <= '1;
            r_vs_dly    <= '1;
            r_blank_dly <= '0;
        end else begin
            r_hs_dly[0]    <= w_hs;
            r_vs_dly[0]    <= w_vs;
            r_blank_dly[0] <= w_video_on;
            for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                r_hs_dly[i]    <= r_hs_dly[i-1];
                r_vs_dly[i]    <= r_vs_dly[i-1];
                r_blank_dly[i] <= r_blank_dly[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign h_counter   = r_h_cnt;
    assign v_counter   = r_v_cnt;
    assign video_on    = w_video_on;
    assign pixel_tick  = w_div_last;
    assign line_start  = w_div_last && w_h_last;
    assign frame_start = w_div_last && w_h_last && w_v_last;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs_dly[SYNC_DELAY-1];
    assign VGA_VS      = r_vs_dly[SYNC_DELAY-1];
    assign VGA_BLANK_N = r_blank_dly[SYNC_DELAY-1];
    assign VGA_SYNC_N  = 1'b0;

    a_strobe_order : assert property (@(posedge clk) disable iff (!rst_n)
        frame_start |-> line_start);
    a_line_tick : assert property (@(posedge clk) disable iff (!rst_n)
        line_start |-> pixel_tick);
    a_h_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_h_cnt < 10'(H_TOTAL - 1) || w_h_last);
    a_v_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_v_cnt < 10'(V_TOTAL - 1) || w_v_last);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken
// instance (CLK_DIV=3, SYNC_DELAY=3) for whole-frame and delay-line behaviour.
module tb_vga_timing_gen;

    localparam int A_DIV = 2;
    localparam int A_SD  = 1;
    localparam int B_DIV = 3;
    localparam int B_SD  = 3;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       von;
        logic       tick;
        logic       ls;
        logic       fs;
        logic       vclk;
    } int_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } pin_t;

    typedef struct {
        int d;
        int hv;
        int hf;
        int hs;
        int hb;
        int vv;
        int vf;
        int vs;
        int vb;
    } geom_t;

    localparam int_t RST_INT = '{h: 10'd0, v: 10'd0, von: 1'b1, tick: 1'b0, ls: 1'b0,
                                 fs: 1'b0, vclk: 1'b0};
    localparam pin_t RST_PIN = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    logic clk;
    logic rst_n;

    logic [9:0] a_h, a_v, b_h, b_v;
    logic a_von, a_tick, a_ls, a_fs, a_vclk, a_hs, a_vs, a_blank, a_syncn;
    logic b_von, b_tick, b_ls, b_fs, b_vclk, b_hs, b_vs, b_blank, b_syncn;

    int_t obs_a, obs_b;
    pin_t pin_a, pin_b;
    assign obs_a = {a_h, a_v, a_von, a_tick, a_ls, a_fs, a_vclk};
    assign obs_b = {b_h, b_v, b_von, b_tick, b_ls, b_fs, b_vclk};
    assign pin_a = {a_hs, a_vs, a_blank};
    assign pin_b = {b_hs, b_vs, b_blank};

    int    n_tests = 0;
    int    n_fail  = 0;
    geom_t ga, gb;
    pin_t  q_a[$];
    pin_t  q_b[$];

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_counter   (a_h),
        .v_counter   (a_v),
        .video_on    (a_von),
        .pixel_tick  (a_tick),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .VGA_CLK     (a_vclk),
        .VGA_HS      (a_hs),
        .VGA_VS      (a_vs),
        .VGA_BLANK_N (a_blank),
        .VGA_SYNC_N  (a_syncn)
    );

    vga_timing_gen #(
        .CLK_DIV    (B_DIV),
        .H_VISIBLE  (16),
        .H_FRONT    (4),
        .H_SYNC     (6),
        .H_BACK     (4),
        .V_VISIBLE  (10),
        .V_FRONT    (2),
        .V_SYNC     (2),
        .V_BACK     (3),
        .SYNC_DELAY (B_SD)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_counter   (b_h),
        .v_counter   (b_v),
        .video_on    (b_von),
        .pixel_tick  (b_tick),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .VGA_CLK     (b_vclk),
        .VGA_HS      (b_hs),
        .VGA_VS      (b_vs),
        .VGA_BLANK_N (b_blank),
        .VGA_SYNC_N  (b_syncn)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected undelayed outputs k clk edges after reset release.
    function automatic int_t model_int(input int k, input geom_t g);
        int   ht, vt, p, h, v, ph;
        int_t e;
        ht     = g.hv + g.hf + g.hs + g.hb;
        vt     = g.vv + g.vf + g.vs + g.vb;
        p      = k / g.d;
        ph     = k % g.d;
        h      = p % ht;
        v      = (p / ht) % vt;
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.von  = (h < g.hv) && (v < g.vv);
        e.tick = (ph == g.d - 1);
        e.ls   = e.tick && (h == ht - 1);
        e.fs   = e.ls && (v == vt - 1);
        e.vclk = (ph >= g.d / 2);
        return e;
    endfunction

    function automatic pin_t model_pin(input int k, input geom_t g);
        int_t e;
        int   h, v;
        pin_t r;
        e         = model_int(k, g);
        h         = int'(e.h);
        v         = int'(e.v);
        r.hs      = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
        r.vs      = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
        r.blank_n = e.von;
        return r;
    endfunction

    // Leaves the bench at k=0 (just after release, before any clk edge).
    task automatic release_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < A_SD; i++) q_a.push_back(RST_PIN);
        for (int i = 0; i < B_SD; i++) q_b.push_back(RST_PIN);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (obs_a !== RST_INT) begin
            n_fail++;
            $display("FAIL reset_int_a: got %h expected %h", obs_a, RST_INT);
        end
        n_tests++;
        if (pin_a !== RST_PIN) begin
            n_fail++;
            $display("FAIL reset_pin_a: got %b expected %b", pin_a, RST_PIN);
        end
        n_tests++;
        if (a_syncn !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_n_a: got %b expected 0", a_syncn);
        end
        n_tests++;
        if (obs_b !== RST_INT) begin
            n_fail++;
            $display("FAIL reset_int_b: got %h expected %h", obs_b, RST_INT);
        end
        n_tests++;
        if (pin_b !== RST_PIN) begin
            n_fail++;
            $display("FAIL reset_pin_b: got %b expected %b", pin_b, RST_PIN);
        end
        n_tests++;
        if (b_syncn !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_n_b: got %b expected 0", b_syncn);
        end
    endtask

    task automatic test_line();
        int   first_tick = -1;
        int   ls_cnt     = 0;
        int   hs_low     = 0;
        int   k656       = -1;
        int   kfall      = -1;
        int_t e;
        pin_t pe;
        release_reset();
        for (int k = 0; k < 3300; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            e = model_int(k, ga);
            q_a.push_back(model_pin(k, ga));
            pe = q_a.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL line_int k=%0d: got %h expected %h", k, obs_a, e);
            end
            n_tests++;
            if (pin_a !== pe) begin
                n_fail++;
                $display("FAIL line_pin k=%0d: got %b expected %b", k, pin_a, pe);
            end
            if (a_tick === 1'b1 && first_tick < 0) first_tick = k;
            if (k < 3200 && a_ls === 1'b1) ls_cnt++;
            if (k < 1600 && a_hs === 1'b0) hs_low++;
            if (a_h === 10'd656 && k656 < 0) k656 = k;
            if (a_hs === 1'b0 && kfall < 0) kfall = k;
        end
        n_tests++;
        if (first_tick != 1) begin
            n_fail++;
            $display("FAIL first_tick: got %0d expected 1", first_tick);
        end
        n_tests++;
        if (ls_cnt != 2) begin
            n_fail++;
            $display("FAIL line_start_count: got %0d expected 2", ls_cnt);
        end
        n_tests++;
        if (hs_low != 192) begin
            n_fail++;
            $display("FAIL hs_width: got %0d expected 192", hs_low);
        end
        n_tests++;
        if (k656 != 1312 || kfall != 1313) begin
            n_fail++;
            $display("FAIL hs_fall: got h656@%0d fall@%0d expected 1312/1313", k656, kfall);
        end
    endtask

    task automatic test_small_frame();
        int   fs_first = -1;
        int   fs_next  = -1;
        int   vid_cnt  = 0;
        int   vs_low   = 0;
        int   kh20     = -1;
        int   kfall    = -1;
        int_t e;
        pin_t pe;
        release_reset();
        for (int k = 0; k < 3200; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            e = model_int(k, gb);
            q_b.push_back(model_pin(k, gb));
            pe = q_b.pop_front();
            n_tests++;
            if (obs_b !== e) begin
                n_fail++;
                $display("FAIL frame_int k=%0d: got %h expected %h", k, obs_b, e);
            end
            n_tests++;
            if (pin_b !== pe) begin
                n_fail++;
                $display("FAIL frame_pin k=%0d: got %b expected %b", k, pin_b, pe);
            end
            if (b_fs === 1'b1) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_next < 0) fs_next = k;
            end
            if (k < 1530 && b_tick === 1'b1 && b_von === 1'b1) vid_cnt++;
            if (k < 1530 && b_vs === 1'b0) vs_low++;
            if (b_h === 10'd20 && kh20 < 0) kh20 = k;
            if (b_hs === 1'b0 && kfall < 0) kfall = k;
        end
        n_tests++;
        if (fs_first != 1529 || fs_next - fs_first != 1530) begin
            n_fail++;
            $display("FAIL frame_period: got first=%0d next=%0d expected 1529/3059",
                     fs_first, fs_next);
        end
        n_tests++;
        if (vid_cnt != 160) begin
            n_fail++;
            $display("FAIL video_pixels: got %0d expected 160", vid_cnt);
        end
        n_tests++;
        if (vs_low != 180) begin
            n_fail++;
            $display("FAIL vs_width: got %0d expected 180", vs_low);
        end
        n_tests++;
        if (kh20 != 60 || kfall != 63) begin
            n_fail++;
            $display("FAIL hs_lag3: got h20@%0d fall@%0d expected 60/63", kh20, kfall);
        end
    endtask

    task automatic test_midframe_reset();
        int   ka = -1;
        int   kb = -1;
        int_t e;
        pin_t pe;
        release_reset();
        repeat (3001) begin
            @(negedge clk);
            #1;
        end
        // Full-size instance is now at h=700, v=1 with HS asserted on the pin.
        e = model_int(3001, ga);
        n_tests++;
        if (obs_a !== e) begin
            n_fail++;
            $display("FAIL pre_reset_a: got %h expected %h", obs_a, e);
        end
        pe = model_pin(3000, ga);
        n_tests++;
        if (pin_a !== pe) begin
            n_fail++;
            $display("FAIL pre_reset_pin_a: got %b expected %b", pin_a, pe);
        end
        e = model_int(3001, gb);
        n_tests++;
        if (obs_b !== e) begin
            n_fail++;
            $display("FAIL pre_reset_b: got %h expected %h", obs_b, e);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_a !== RST_INT || pin_a !== RST_PIN) begin
            n_fail++;
            $display("FAIL async_reset_a: got %h/%b expected %h/%b", obs_a, pin_a, RST_INT,
                     RST_PIN);
        end
        n_tests++;
        if (obs_b !== RST_INT || pin_b !== RST_PIN) begin
            n_fail++;
            $display("FAIL async_reset_b: got %h/%b expected %h/%b", obs_b, pin_b, RST_INT,
                     RST_PIN);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs_a !== RST_INT || obs_b !== RST_INT) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%h expected %h", obs_a, obs_b, RST_INT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (a_ls === 1'b1 && ka < 0) ka = k;
            if (b_ls === 1'b1 && kb < 0) kb = k;
            if (ka >= 0 && kb >= 0) break;
        end
        n_tests++;
        if (ka != 1599) begin
            n_fail++;
            $display("FAIL post_reset_line_a: got %0d expected 1599", ka);
        end
        n_tests++;
        if (kb != 89) begin
            n_fail++;
            $display("FAIL post_reset_line_b: got %0d expected 89", kb);
        end
    endtask

    initial begin
        ga = '{d: A_DIV, hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33};
        gb = '{d: B_DIV, hv: 16, hf: 4, hs: 6, hb: 4, vv: 10, vf: 2, vs: 2, vb: 3};
        rst_n = 1'b0;
        test_reset();
        test_line();
        test_small_frame();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
